// File: rtl/int_to_fp_converter.sv
// Signed integer to 13-bit float (1 sign, 4 exponent, 8 mantissa) converter.
// Normalises iteratively, one left shift per clock, with valid/ready on both sides.
module int_to_fp_converter #(
  parameter int unsigned INT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_int,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      out_fp,
  output logic             out_inexact
);

  localparam int unsigned EXP_W = 4;
  localparam int unsigned MAN_W = 8;
  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

  // Bits below the mantissa window that are lost to truncation; empty when INT_W == MAN_W.
  localparam logic [INT_W-1:0] LOW_MASK = INT_W'((32'd1 << (INT_W - MAN_W)) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [FP_W-1:0]   fp_q, fp_d;
  logic              inexact_q, inexact_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      fp_q      <= '0;
      inexact_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      fp_q      <= fp_d;
      inexact_q <= inexact_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    fp_d      = fp_q;
    inexact_d = inexact_q;
    valid_d   = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = in_int[INT_W-1];
          // Unsigned magnitude: the most negative input maps to 2^(INT_W-1) without overflow.
          mag_d   = in_int[INT_W-1] ? (~in_int + INT_W'(1)) : in_int;
          exp_d   = EXP_W'(INT_W);
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q == '0) begin
          fp_d      = '0;
          inexact_d = 1'b0;
          sign_d    = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_DONE;
        end else if (mag_q[INT_W-1]) begin
          fp_d      = {sign_q, exp_q, mag_q[INT_W-1 -: MAN_W]};
          inexact_d = |(mag_q & LOW_MASK);
          valid_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = valid_q;
  assign out_fp      = fp_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed bench for int_to_fp_converter: hand-computed results, latencies,
// backpressure and mid-conversion reset.
module tb_int_to_fp_converter;

  localparam int unsigned INT_W   = 12;
  localparam int unsigned MAX_LAT = 40;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] in_int;
  logic             out_valid;
  logic             out_ready;
  logic [12:0]      out_fp;
  logic             out_inexact;

  int errors;
  int checks;

  int_to_fp_converter #(.INT_W(INT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_int      (in_int),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one integer at a negedge and returns once out_valid is seen (or the budget expires).
  task automatic start_conv(input string tag, input logic [INT_W-1:0] v, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_int   = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < MAX_LAT);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic convert(input string tag, input logic [INT_W-1:0] v, input int exp_lat,
                         input logic [12:0] exp_fp, input logic exp_inex);
    out_ready = 1'b1;
    start_conv(tag, v, exp_lat);
    check({tag, "_fp"}, 32'(out_fp), 32'(exp_fp));
    check({tag, "_inexact"}, 32'(out_inexact), 32'(exp_inex));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [12:0] held;
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_int    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fp", 32'(out_fp), 32'd0);
    check("rst_out_inexact", 32'(out_inexact), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    convert("p5",    12'd5,    10, 13'h03A0, 1'b0);
    convert("m2048", 12'h800,  1,  13'h1C80, 1'b0);
    convert("p2047", 12'd2047, 2,  13'h0BFF, 1'b1);
    convert("p256",  12'd256,  4,  13'h0980, 1'b0);
    convert("p1",    12'd1,    12, 13'h0180, 1'b0);
    convert("zero",  12'd0,    1,  13'h0000, 1'b0);
    convert("m1",    12'hFFF,  12, 13'h1180, 1'b0);

    // Backpressure: result held while out_ready is low, second input refused.
    out_ready = 1'b0;
    start_conv("m5", 12'hFFB, 10);
    held = out_fp;
    check("m5_fp", 32'(out_fp), 32'h13A0);
    in_valid = 1'b1;
    in_int   = 12'd7;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_fp_hold", 32'(out_fp), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_no_phantom", 32'(in_ready), 32'd1);
    check("bp_fp_kept", 32'(out_fp), 32'h13A0);

    // Reset in the middle of a normalisation discards the conversion.
    check("mid_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_int   = 12'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fp", 32'(out_fp), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    convert("p3", 12'd3, 11, 13'h02C0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_to_fp_converter.md
Name: int_to_fp_converter

Overview:
- Sequential converter from a signed two's-complement integer to the team's 13-bit floating-point format: 1 sign bit, 4 exponent bits, 8 mantissa bits.
- It produces operands for the fp comparison and arithmetic blocks.
- Normalisation is iterative, one left shift per clock, to keep the logic small.
- Input and output each use a valid/ready handshake. One conversion is in flight at a time.

Parameters:
- INT_W, 12: input integer width. Legal range 8..15, so the maximum exponent INT_W fits in 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_int is valid.
- in_ready  output  1  converter can accept a new integer.
- in_int  input  INT_W  signed two's-complement integer.
- out_valid  output  1  out_fp and out_inexact are valid.
- out_ready  input  1  consumer accepts the result.
- out_fp  output  13  result: [12] sign, [11:8] exponent, [7:0] mantissa.
- out_inexact  output  1  nonzero magnitude bits were truncated.

Behaviour:
- Format:
  - value = (-1)^s × 0.m7m6..m0 × 2^e, with e unsigned 0..15.
  - A nonzero result is normalised: m7 = 1.
  - Zero is all 13 bits 0 with sign 0. There is no negative zero.
- Reset (synchronous, checked on the edge, overrides everything):
  - state goes to IDLE; in_ready=1, out_valid=0, out_fp=0, out_inexact=0.
  - Internal magnitude and exponent registers are cleared.
  - Any in-flight conversion is discarded. A pending out_valid is dropped with no handshake.
- All outputs are registered. in_ready is decoded from the state register.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - sign ← in_int[INT_W-1].
    - mag (INT_W bits, unsigned) ← |in_int|.
    - exp ← INT_W.
    - Go to NORM.
  - The most negative input -2^(INT_W-1) gives mag = 2^(INT_W-1) with no overflow.
  - in_valid=0: stay in IDLE.
- NORM (in_ready=0):
  - If mag==0:
    - out_fp ← 0, out_inexact ← 0, sign forced to 0.
    - Go to DONE.
  - Else if mag[INT_W-1]==1:
    - out_fp ← {sign, exp[3:0], mag[INT_W-1:INT_W-8]}.
    - out_inexact ← |mag[INT_W-9:0]. This is 0 when INT_W==8.
    - Go to DONE.
  - Else:
    - mag ← mag<<1, exp ← exp-1.
    - Stay in NORM.
  - exp never goes below 1 for a nonzero input.
- DONE:
  - out_valid=1. out_fp and out_inexact are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid ← 0, go to IDLE. in_ready is 1 in the following cycle.
  - There is no same-cycle output-accept/input-accept overlap.
- Latency:
  - With accept at edge k and L = leading zeros of mag, out_valid is first high after edge k+1+L.
  - Zero input: after edge k+1.
  - Worst case (|in_int|==1): after edge k+INT_W.
  - Throughput is one result per (L+3) cycles minimum, assuming out_ready is already high.
- Rounding: truncation of the magnitude toward zero. out_inexact flags discarded bits.
- Inputs while busy: in_valid in NORM/DONE is ignored (in_ready=0). The upstream holds its data.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset, then in_int=5 with out_ready=1 → out_valid rises 10 edges after accept; out_fp=13'h03A0, out_inexact=0; in_ready back to 1 one cycle after the output handshake.
- in_int=-2048 (12'h800) → L=0, out_valid after edge k+1; out_fp=13'h1C80, out_inexact=0.
- in_int=2047 → out_fp=13'h0BFF, out_inexact=1. in_int=256 → out_fp=13'h0980, out_inexact=0. in_int=1 → out_fp=13'h0180, valid after edge k+12.
- in_int=0 → out_fp=13'h0000, out_inexact=0, valid after edge k+1. in_int=-1 → out_fp=13'h1180.
- Backpressure: in_int=-5, out_ready=0 for 6 cycles → out_fp=13'h13A0 held stable with out_valid=1; in_ready=0 and a second in_valid is not accepted; completes when out_ready=1.
- Reset asserted mid-NORM (in_int=3 accepted, reset 2 cycles later) → next edge: out_valid=0, out_fp=0, in_ready=1; a following in_int=3 yields out_fp=13'h02C0.
